// File: rtl/video_ar_pkg.sv
// Shared types and constants for the aspect-ratio viewport calculator.
// Used by video_ar_window and video_ar_div (rounding option: VIDEO_AR_ROUND_EN).
package video_ar_pkg;

    localparam int AR_ABS_BIT = 12;
    localparam int RES_W      = 12;
    localparam int AR_W       = 13;
    localparam int DEN_W      = 12;
    localparam int PROD_W     = 2 * RES_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_DIVW,
        ST_DIVH,
        ST_CENTER,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_FULL,
        MODE_ABS,
        MODE_RATIO
    } ar_mode_t;

    typedef struct packed {
        logic [RES_W-1:0] width;
        logic [RES_W-1:0] height;
        logic [AR_W-1:0]  arx;
        logic [AR_W-1:0]  ary;
    } snap_t;

    // A zero component or mixed absolute/ratio flags fall back to full screen.
    function automatic ar_mode_t decode_mode(input logic [AR_W-1:0] arx,
                                             input logic [AR_W-1:0] ary);
        ar_mode_t mode;
        if (arx[RES_W-1:0] == '0 || ary[RES_W-1:0] == '0 ||
            arx[AR_ABS_BIT] != ary[AR_ABS_BIT]) begin
            mode = MODE_FULL;
        end else if (arx[AR_ABS_BIT]) begin
            mode = MODE_ABS;
        end else begin
            mode = MODE_RATIO;
        end
        return mode;
    endfunction

endpackage

// File: rtl/video_ar_div.sv
// Restoring divider, one quotient bit per cycle; result DIV_W+1 cycles after start.
// Build option VIDEO_AR_ROUND_EN adds den>>1 to the numerator for round-to-nearest.
module video_ar_div
    import video_ar_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DIV_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic [DIV_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] quo_reg;
    logic [DEN_W-1:0] rem_reg;
    logic [DEN_W-1:0] den_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;

    logic [DIV_W-1:0] num_adj;
    logic [DEN_W:0]   rem_shift;
    logic [DEN_W:0]   rem_diff;
    logic             q_bit;

`ifdef VIDEO_AR_ROUND_EN
    // A 12x12 product plus half a 12-bit divisor still fits in 24 bits.
    assign num_adj = num + DIV_W'(den >> 1);
`else
    assign num_adj = num;
`endif

    assign rem_shift = {rem_reg, quo_reg[DIV_W-1]};
    assign rem_diff  = rem_shift - {1'b0, den_reg};
    assign q_bit     = (rem_shift >= {1'b0, den_reg});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            quo_reg  <= '0;
            rem_reg  <= '0;
            den_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            quo_reg  <= num_adj;
            rem_reg  <= '0;
            den_reg  <= den;
            cnt_reg  <= CNT_W'(DIV_W);
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            // Partial remainder stays below den, so DEN_W bits suffice.
            rem_reg <= q_bit ? rem_diff[DEN_W-1:0] : rem_shift[DEN_W-1:0];
            quo_reg <= {quo_reg[DIV_W-2:0], q_bit};
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy     = busy_reg;
    assign quotient = quo_reg;

endmodule

// File: rtl/video_ar_window.sv
// Computes the centred output viewport from VIDEO_ARX/VIDEO_ARY and the HDMI resolution.
// Build option VIDEO_AR_ROUND_EN selects round-to-nearest ratio division.
module video_ar_window
    import video_ar_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             CLK_VIDEO,
    input  logic             RESET_N,
    input  logic [RES_W-1:0] HDMI_WIDTH,
    input  logic [RES_W-1:0] HDMI_HEIGHT,
    input  logic [AR_W-1:0]  VIDEO_ARX,
    input  logic [AR_W-1:0]  VIDEO_ARY,
    output logic [RES_W-1:0] WIN_HMIN,
    output logic [RES_W-1:0] WIN_HMAX,
    output logic [RES_W-1:0] WIN_VMIN,
    output logic [RES_W-1:0] WIN_VMAX,
    output logic             WIN_VALID,
    output logic             BUSY
);

    state_t                 state_reg, state_next;
    snap_t                  snap_reg, snap_next;
    snap_t                  live;
    logic                   stale_reg, stale_next;
    logic                   busy_reg, busy_next;
    logic [RES_W-1:0]       w_reg, w_next;
    logic [RES_W-1:0]       h_reg, h_next;
    logic [DIV_W-1:0]       prod_reg, prod_next;
    logic                   started_reg, started_next;
    logic                   res_valid_reg, res_valid_next;
    logic [1:0][RES_W-1:0]  ctr_min_reg, ctr_min_next;
    logic [1:0][RES_W-1:0]  ctr_max_reg, ctr_max_next;
    logic [1:0][RES_W-1:0]  win_min_reg, win_min_next;
    logic [1:0][RES_W-1:0]  win_max_reg, win_max_next;
    logic                   win_valid_reg, win_valid_next;

    logic [RES_W-1:0]       mult_a, mult_b;
    logic [PROD_W-1:0]      mult_product;
    logic                   div_start, div_busy;
    logic [DEN_W-1:0]       div_den;
    logic [DIV_W-1:0]       quotient;
    logic [1:0][RES_W-1:0]  axis_size, axis_len, axis_min, axis_max;
    ar_mode_t               mode;

    assign live         = {HDMI_WIDTH, HDMI_HEIGHT, VIDEO_ARX, VIDEO_ARY};
    assign mode         = decode_mode(snap_reg.arx, snap_reg.ary);
    assign mult_product = PROD_W'(mult_a) * PROD_W'(mult_b);
    assign div_den      = (state_reg == ST_DIVH) ? snap_reg.arx[RES_W-1:0]
                                                 : snap_reg.ary[RES_W-1:0];

    // Axis 0 is horizontal, axis 1 vertical; both centre the same way.
    assign axis_size = {snap_reg.height, snap_reg.width};
    assign axis_len  = {h_reg, w_reg};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            assign axis_min[gi] = (axis_size[gi] - axis_len[gi]) >> 1;
            assign axis_max[gi] = axis_min[gi] + axis_len[gi] - RES_W'(1);
        end
    endgenerate

    video_ar_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk     (CLK_VIDEO),
        .reset_n (RESET_N),
        .start   (div_start),
        .num     (prod_reg),
        .den     (div_den),
        .busy    (div_busy),
        .quotient(quotient)
    );

    always_comb begin
        state_next     = state_reg;
        snap_next      = snap_reg;
        stale_next     = stale_reg;
        busy_next      = busy_reg;
        w_next         = w_reg;
        h_next         = h_reg;
        prod_next      = prod_reg;
        started_next   = started_reg;
        res_valid_next = res_valid_reg;
        ctr_min_next   = ctr_min_reg;
        ctr_max_next   = ctr_max_reg;
        win_min_next   = win_min_reg;
        win_max_next   = win_max_reg;
        win_valid_next = win_valid_reg;
        div_start      = 1'b0;
        mult_a         = snap_reg.height;
        mult_b         = snap_reg.arx[RES_W-1:0];

        case (state_reg)
            ST_IDLE: begin
                if (stale_reg || live != snap_reg) begin
                    snap_next  = live;
                    stale_next = 1'b0;
                    busy_next  = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                started_next = 1'b0;
                if (snap_reg.width == '0 || snap_reg.height == '0) begin
                    ctr_min_next   = '0;
                    ctr_max_next   = '0;
                    res_valid_next = 1'b0;
                    state_next     = ST_DONE;
                end else begin
                    case (mode)
                        MODE_ABS: begin
                            w_next = (snap_reg.arx[RES_W-1:0] < snap_reg.width)
                                   ? snap_reg.arx[RES_W-1:0] : snap_reg.width;
                            h_next = (snap_reg.ary[RES_W-1:0] < snap_reg.height)
                                   ? snap_reg.ary[RES_W-1:0] : snap_reg.height;
                            state_next = ST_CENTER;
                        end
                        MODE_RATIO: begin
                            prod_next  = DIV_W'(mult_product);
                            state_next = ST_DIVW;
                        end
                        default: begin
                            w_next     = snap_reg.width;
                            h_next     = snap_reg.height;
                            state_next = ST_CENTER;
                        end
                    endcase
                end
            end
            ST_DIVW: begin
                // Width*ary is prepared here in case the height-limited path is needed.
                mult_a = snap_reg.width;
                mult_b = snap_reg.ary[RES_W-1:0];
                if (!started_reg) begin
                    div_start    = 1'b1;
                    started_next = 1'b1;
                end else if (!div_busy) begin
                    started_next = 1'b0;
                    if (quotient <= DIV_W'(snap_reg.width)) begin
                        w_next     = quotient[RES_W-1:0];
                        h_next     = snap_reg.height;
                        state_next = ST_CENTER;
                    end else begin
                        prod_next  = DIV_W'(mult_product);
                        state_next = ST_DIVH;
                    end
                end
            end
            ST_DIVH: begin
                if (!started_reg) begin
                    div_start    = 1'b1;
                    started_next = 1'b1;
                end else if (!div_busy) begin
                    started_next = 1'b0;
                    w_next       = snap_reg.width;
                    h_next       = (quotient <= DIV_W'(snap_reg.height))
                                 ? quotient[RES_W-1:0] : snap_reg.height;
                    state_next   = ST_CENTER;
                end
            end
            ST_CENTER: begin
                ctr_min_next   = axis_min;
                ctr_max_next   = axis_max;
                res_valid_next = 1'b1;
                state_next     = ST_DONE;
            end
            ST_DONE: begin
                win_min_next   = ctr_min_reg;
                win_max_next   = ctr_max_reg;
                win_valid_next = res_valid_reg;
                busy_next      = 1'b0;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            state_reg     <= ST_IDLE;
            snap_reg      <= '0;
            stale_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            w_reg         <= '0;
            h_reg         <= '0;
            prod_reg      <= '0;
            started_reg   <= 1'b0;
            res_valid_reg <= 1'b0;
            ctr_min_reg   <= '0;
            ctr_max_reg   <= '0;
            win_min_reg   <= '0;
            win_max_reg   <= '0;
            win_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            snap_reg      <= snap_next;
            stale_reg     <= stale_next;
            busy_reg      <= busy_next;
            w_reg         <= w_next;
            h_reg         <= h_next;
            prod_reg      <= prod_next;
            started_reg   <= started_next;
            res_valid_reg <= res_valid_next;
            ctr_min_reg   <= ctr_min_next;
            ctr_max_reg   <= ctr_max_next;
            win_min_reg   <= win_min_next;
            win_max_reg   <= win_max_next;
            win_valid_reg <= win_valid_next;
        end
    end

    assign WIN_HMIN  = win_min_reg[0];
    assign WIN_HMAX  = win_max_reg[0];
    assign WIN_VMIN  = win_min_reg[1];
    assign WIN_VMAX  = win_max_reg[1];
    assign WIN_VALID = win_valid_reg;
    assign BUSY      = busy_reg;

endmodule

// File: tb/tb_video_ar_window.sv
// Randomized self-checking bench for video_ar_window against an arithmetic viewport model.
module tb_video_ar_window;

    localparam int DIV_W = 24;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] hdmi_width, hdmi_height;
    logic [12:0] video_arx, video_ary;
    logic [11:0] win_hmin, win_hmax, win_vmin, win_vmax;
    logic        win_valid, busy;

    int n_compared   = 0;
    int n_mismatched = 0;
    int last_w, last_h, last_arx, last_ary;

    always #5 clk = ~clk;

    video_ar_window #(
        .DIV_W(DIV_W)
    ) dut (
        .CLK_VIDEO  (clk),
        .RESET_N    (reset_n),
        .HDMI_WIDTH (hdmi_width),
        .HDMI_HEIGHT(hdmi_height),
        .VIDEO_ARX  (video_arx),
        .VIDEO_ARY  (video_ary),
        .WIN_HMIN   (win_hmin),
        .WIN_HMAX   (win_hmax),
        .WIN_VMIN   (win_vmin),
        .WIN_VMAX   (win_vmax),
        .WIN_VALID  (win_valid),
        .BUSY       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int div_model(input int num, input int den);
`ifdef VIDEO_AR_ROUND_EN
        return (num + den / 2) / den;
`else
        return num / den;
`endif
    endfunction

    // Window from the mode rules; lat = expected BUSY cycles (-1: not specified).
    function automatic void model(input int W, input int H, input int arx, input int ary,
                                  output int hmin, output int hmax, output int vmin,
                                  output int vmax, output int valid, output int lat);
        int ax, ay, bx, by, w, h, q;
        ax = arx % 4096;  ay = ary % 4096;
        bx = arx / 4096;  by = ary / 4096;
        if (W == 0 || H == 0) begin
            hmin = 0; hmax = 0; vmin = 0; vmax = 0; valid = 0; lat = -1;
            return;
        end
        if (ax == 0 || ay == 0 || bx != by) begin
            w = W; h = H; lat = 3;
        end else if (bx == 1) begin
            w = (ax < W) ? ax : W;
            h = (ay < H) ? ay : H;
            lat = 3;
        end else begin
            q = div_model(H * ax, ay);
            if (q <= W) begin
                w = q; h = H; lat = 3 + DIV_W + 2;
            end else begin
                q = div_model(W * ay, ax);
                h = (q < H) ? q : H; w = W; lat = 3 + 2 * (DIV_W + 2);
            end
        end
        hmin = (W - w) / 2;
        hmax = (hmin + w - 1 + 4096) % 4096;
        vmin = (H - h) / 2;
        vmax = (vmin + h - 1 + 4096) % 4096;
        valid = 1;
    endfunction

    task automatic drive(input int W, input int H, input int arx, input int ary);
        hdmi_width  = 12'(W);
        hdmi_height = 12'(H);
        video_arx   = 13'(arx);
        video_ary   = 13'(ary);
        last_w = W; last_h = H; last_arx = arx; last_ary = ary;
    endtask

    task automatic wait_rise(input string tag);
        int n = 0;
        while (!busy && n < 8) begin
            n++;
            @(negedge clk);
        end
        check_val({tag, "/busy_rise"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_fall(input string tag, output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        check_val({tag, "/busy_fall"}, 32'(busy), 32'd0);
    endtask

    task automatic check_win(input string tag, input int W, input int H, input int arx,
                             input int ary, input int cycles, input bit chk_lat);
        int hmin, hmax, vmin, vmax, valid, lat;
        model(W, H, arx, ary, hmin, hmax, vmin, vmax, valid, lat);
        check_val({tag, "/hmin"}, 32'(win_hmin), hmin);
        check_val({tag, "/hmax"}, 32'(win_hmax), hmax);
        check_val({tag, "/vmin"}, 32'(win_vmin), vmin);
        check_val({tag, "/vmax"}, 32'(win_vmax), vmax);
        check_val({tag, "/valid"}, 32'(win_valid), valid);
        if (chk_lat && lat >= 0) check_val({tag, "/latency"}, cycles, lat);
        $display("case %s: %0dx%0d arx=%h ary=%h -> H %0d..%0d V %0d..%0d valid=%0d busy=%0d",
                 tag, W, H, arx, ary, win_hmin, win_hmax, win_vmin, win_vmax, win_valid, cycles);
    endtask

    task automatic run_case(input string tag, input int W, input int H, input int arx,
                            input int ary);
        int cycles;
        @(posedge clk);
        #1;
        drive(W, H, arx, ary);
        @(negedge clk);
        wait_rise(tag);
        wait_fall(tag, cycles);
        check_win(tag, W, H, arx, ary, cycles, 1'b1);
    endtask

    initial begin
        int cycles, W, H, arx, ary, m;

        reset_n = 1'b0;
        drive(1920, 1080, 4, 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset/hmax", 32'(win_hmax), 32'd0);
        check_val("reset/valid", 32'(win_valid), 32'd0);
        check_val("reset/busy", 32'(busy), 32'd0);

        // First computation triggers on the stale snapshot right after release.
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        wait_rise("ar4x3");
        wait_fall("ar4x3", cycles);
        check_win("ar4x3", 1920, 1080, 4, 3, cycles, 1'b1);
        check_val("ar4x3/hmin_const", 32'(win_hmin), 32'd240);
        check_val("ar4x3/hmax_const", 32'(win_hmax), 32'd1679);

        run_case("ar16x9_divh", 1280, 1024, 16, 9);
        check_val("ar16x9_divh/vmin_const", 32'(win_vmin), 32'd152);
        run_case("abs1280x960", 1920, 1080, 'h1500, 'h13C0);
        check_val("abs1280x960/hmin_const", 32'(win_hmin), 32'd320);
        run_case("abs_clamp", 1920, 1080, 'h1000 + 2000, 'h1000 + 1200);
        run_case("arx_zero", 1920, 1080, 0, 3);
        run_case("hdmi_w_zero", 0, 1080, 4, 3);
        run_case("mixed_flag", 1920, 1080, 'h1004, 3);
        run_case("ar10x7", 1920, 1080, 10, 7);
`ifdef VIDEO_AR_ROUND_EN
        check_val("ar10x7/hmin_const", 32'(win_hmin), 32'd188);
`else
        check_val("ar10x7/hmin_const", 32'(win_hmin), 32'd189);
`endif

        for (int i = 0; i < 40; i++) begin
            do begin
                W = $urandom_range(4095, 1);
                H = $urandom_range(4095, 1);
                if ($urandom_range(15) == 0) W = 0;
                if ($urandom_range(15) == 0) H = 0;
                m = $urandom_range(3);
                case (m)
                    0: begin arx = $urandom_range(31, 1); ary = $urandom_range(31, 1); end
                    1: begin arx = $urandom_range(4095, 1); ary = $urandom_range(4095, 1); end
                    2: begin arx = 4096 + $urandom_range(4095); ary = 4096 + $urandom_range(4095); end
                    default: begin arx = $urandom_range(8191); ary = $urandom_range(8191); end
                endcase
            end while (W == last_w && H == last_h && arx == last_arx && ary == last_ary);
            run_case($sformatf("rand%0d", i), W, H, arx, ary);
        end

        // Input change mid-DIVW: first result is the old ratio, then an immediate recompute.
        @(posedge clk);
        #1;
        drive(1920, 1080, 4, 3);
        @(negedge clk);
        wait_rise("chg");
        repeat (10) @(negedge clk);
        drive(1920, 1080, 16, 9);
        wait_fall("chg_first", cycles);
        check_win("chg_first", 1920, 1080, 4, 3, cycles, 1'b0);
        @(negedge clk);
        check_val("chg/recompute", 32'(busy), 32'd1);
        wait_fall("chg_final", cycles);
        check_win("chg_final", 1920, 1080, 16, 9, cycles, 1'b0);
        check_val("chg_final/hmax_const", 32'(win_hmax), 32'd1919);

        // Reset pulse while the height-limited division is running.
        @(posedge clk);
        #1;
        drive(1280, 1024, 16, 9);
        @(negedge clk);
        wait_rise("rst_mid");
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_val("rst_mid/hmax", 32'(win_hmax), 32'd0);
        check_val("rst_mid/vmax", 32'(win_vmax), 32'd0);
        check_val("rst_mid/valid", 32'(win_valid), 32'd0);
        check_val("rst_mid/busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wait_rise("rst_after");
        wait_fall("rst_after", cycles);
        check_win("rst_after", 1280, 1024, 16, 9, cycles, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/video_ar_window.md
Name: video_ar_window

Overview:
- Consumer side of the aspect-ratio interface.
- Takes the 13-bit VIDEO_ARX/VIDEO_ARY pair from the crop/integer-scale block plus the HDMI output resolution.
- Computes the centred output viewport rectangle that the scaler writes into.
- Iterative multiply/divide FSM; recomputes automatically whenever any input changes.

Parameters:
- DIV_W, 24, dividend/quotient width of the internal divider (divisor fixed at 12).

Ports:
- CLK_VIDEO  in  1  video clock.
- RESET_N  in  1  synchronous active-low reset.
- HDMI_WIDTH  in  12  output horizontal resolution.
- HDMI_HEIGHT  in  12  output vertical resolution.
- VIDEO_ARX  in  13  bit12=1: absolute width in [11:0]; bit12=0: ratio X.
- VIDEO_ARY  in  13  bit12=1: absolute height in [11:0]; bit12=0: ratio Y.
- WIN_HMIN  out  12  first active output column.
- WIN_HMAX  out  12  last active output column.
- WIN_VMIN  out  12  first active output line.
- WIN_VMAX  out  12  last active output line.
- WIN_VALID  out  1  window holds a valid result.
- BUSY  out  1  computation in progress.

Behaviour:
- Reset: all WIN_* outputs = 0, WIN_VALID = 0, BUSY = 0, FSM = IDLE, snapshot marked stale. Computation starts on the first cycle after reset release.
- Reset asserted mid-computation: abort in the same cycle, restore the reset values.
- Snapshot register holds {HDMI_WIDTH, HDMI_HEIGHT, VIDEO_ARX, VIDEO_ARY}.
- IDLE: if the inputs differ from the snapshot or the snapshot is stale, load the snapshot, set BUSY = 1, go to DECODE.
- Inputs changing while BUSY are ignored. They are caught by the compare on the return to IDLE, so the outputs always converge to the latest inputs.
- DECODE selects the mode and computes the window size w×h:
  - HDMI_WIDTH = 0 or HDMI_HEIGHT = 0: window = 0, WIN_VALID = 0, go to DONE.
  - ARX[11:0] = 0, ARY[11:0] = 0, or ARX[12] ≠ ARY[12]: full screen, w = HDMI_WIDTH, h = HDMI_HEIGHT, go to CENTER.
  - Both bit12 = 1 (absolute): w = min(ARX[11:0], HDMI_WIDTH), h = min(ARY[11:0], HDMI_HEIGHT), go to CENTER.
  - Both bit12 = 0 (ratio): go to DIVW.
- DIVW: w' = (HDMI_HEIGHT·arx)/ary. Product is 24-bit, unsigned; quotient is truncated.
  - If quotient ≤ HDMI_WIDTH (all upper quotient bits zero): w = w', h = HDMI_HEIGHT, go to CENTER.
  - Otherwise go to DIVH.
- DIVH: h = min((HDMI_WIDTH·ary)/arx, HDMI_HEIGHT), w = HDMI_WIDTH.
- CENTER:
  - hmin = (HDMI_WIDTH − w)>>1, hmax = hmin + w − 1.
  - vmin = (HDMI_HEIGHT − h)>>1, vmax = vmin + h − 1.
  - All 12-bit unsigned.
- DONE: all four WIN_* outputs and WIN_VALID = 1 update in the same cycle (atomic). BUSY drops in that cycle. Return to IDLE.
- Latency from the trigger cycle to the DONE update:
  - Absolute or full-screen mode: 3 cycles.
  - Ratio mode without DIVH: 3 + DIV_W + 2 cycles.
  - Ratio mode with DIVH: 3 + 2·(DIV_W + 2) cycles.
- Divider: restoring, 1 quotient bit per cycle. Division by 0 is unreachable (excluded in DECODE).
- Multiplier: single-cycle combinational 12×12, registered before the divider.

Optional Feature:
- Macro VIDEO_AR_ROUND_EN.
- Defined: each ratio division adds divisor>>1 to the numerator before dividing, giving round-to-nearest. The DIVW comparison uses the rounded quotient.
- Undefined: truncating division. Latency is identical in both builds.

Decomposition:
- Shared package video_ar_pkg holds:
  - The FSM state enum.
  - AR_ABS_BIT = 12.
  - Width constants.
  - A function decoding the VIDEO_ARX/VIDEO_ARY mode (ratio/absolute/full-screen).
- One sub-module, video_ar_div: DIV_W/12 restoring divider with start, busy, num, den and quotient ports. Fixed latency DIV_W + 1 cycles from start to result. The rounding option is implemented inside it.

Test Plan:
- Reset, then 1920×1080 with ARX=4, ARY=3 → BUSY for the ratio latency, then H 240..1679, V 0..1079, WIN_VALID=1.
- 1280×1024 with 16:9 → 1820 > 1280, DIVH path → H 0..1279, V 152..871.
- 1920×1080 with ARX=0x1500, ARY=0x13C0 (1280×960 absolute) → H 320..1599, V 60..1019 within 3 cycles.
- Boundary cases:
  - Absolute 2000×1200 on 1920×1080 → clamped to H 0..1919, V 0..1079.
  - ARX=0 → full screen.
  - HDMI_WIDTH=0 → WIN_VALID=0.
- 1920×1080 with 10:7 → truncating build: H 189..1730; VIDEO_AR_ROUND_EN build: H 188..1730.
- Change ARX from 4 to 16 mid-DIVW → first DONE reflects 4:3, immediate recompute, final H 0..1919 for 16:9 on 1920×1080. RESET_N pulsed mid-DIVH → outputs 0 next cycle, recompute after release.
